// File: rtl/mpu_pkg.sv
// ----------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the MPU memory load stage.
//   - field size encodings used on ld_size / w_size
//   - load unit state encoding
//   - data word width
//   - helper that builds the byte-offset alignment mask for a field size
// ----------------------------------------------------------------------------
package mpu_pkg;

    // Width of one memory word and of one register file write.
    localparam int DATA_W = 64;

    // Field size encodings: the value is log2 of the field width in bytes.
    localparam logic [1:0] SZ_8  = 2'd0;
    localparam logic [1:0] SZ_16 = 2'd1;
    localparam logic [1:0] SZ_32 = 2'd2;
    localparam logic [1:0] SZ_64 = 2'd3;

    // Load unit states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        ERR  = 2'd3
    } ld_state_e;

    // Byte-offset bits that must be zero for a field of this size to be
    // naturally aligned inside the 64-bit word: (1 << size) - 1.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            SZ_8:    mask = 3'b000;
            SZ_16:   mask = 3'b001;
            SZ_32:   mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mpu_load_unit.sv
// ----------------------------------------------------------------------------
// mpu_load_unit
// Memory load stage of the MPU, sitting directly upstream of the register
// file write port. It accepts one load at a time, fetches the aligned 64-bit
// word over a req/ack handshake and presents the raw word together with the
// field selectors so the register file can extract and merge the field.
//
// Optional build macro:
//   MPU_LOAD_TIMEOUT_EN - when defined, a request that sees no mem_ack for
//                         TIMEOUT cycles is abandoned and reported on err.
//                         When undefined, REQ waits indefinitely.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   synchronous reset, active-low
//   ld_valid   in   load operation valid
//   ld_ready   out  unit can accept an operation (IDLE only)
//   ld_addr    in   byte address
//   ld_size    in   field size (0=8, 1=16, 2=32, 3=64 bits)
//   ld_dst     in   destination register index
//   ld_r_sel   in   destination field index within the destination register
//   mem_req    out  memory request, held until mem_ack
//   mem_addr   out  8-byte-aligned word address
//   mem_ack    in   memory acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  in   memory read word
//   w_idx      out  register file write index
//   w_data     out  raw memory word
//   w_sel      out  source field index within the memory word
//   w_r_sel    out  destination field index
//   w_size     out  field size
//   we         out  register file write strobe, one cycle
//   err        out  one-cycle pulse for a misaligned or aborted load
//   busy       out  high whenever the unit is not IDLE
// ----------------------------------------------------------------------------
module mpu_load_unit
    import mpu_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int IDX_W   = NB_REG / 8 + 1,
`ifdef MPU_LOAD_TIMEOUT_EN
    parameter int TIMEOUT = 255,
`endif
    parameter int ADDR_W  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic [IDX_W-1:0]  ld_dst,
    input  logic [2:0]        ld_r_sel,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [IDX_W-1:0]  w_idx,
    output logic [DATA_W-1:0] w_data,
    output logic [2:0]        w_sel,
    output logic [2:0]        w_r_sel,
    output logic [1:0]        w_size,
    output logic              we,
    output logic              err,
    output logic              busy
);

    ld_state_e state_q, state_d;

    // Operation fields captured at acceptance.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [IDX_W-1:0]  dst_q, dst_d;
    logic [2:0]        rsel_q, rsel_d;

    // Write port fields. These are only refreshed when a word returns, so
    // they keep their last values between writes and across error loads.
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [2:0]        wsel_q, wsel_d;
    logic [2:0]        wrsel_q, wrsel_d;
    logic [1:0]        wsize_q, wsize_d;

    logic misaligned;

`ifdef MPU_LOAD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Any set offset bit below the field size means the field would straddle
    // its natural slot, which the register file cannot extract.
    assign misaligned = |(ld_addr[2:0] & align_mask(ld_size));

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            dst_q   <= '0;
            rsel_q  <= '0;
            wdata_q <= '0;
            widx_q  <= '0;
            wsel_q  <= '0;
            wrsel_q <= '0;
            wsize_q <= '0;
`ifdef MPU_LOAD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            dst_q   <= dst_d;
            rsel_q  <= rsel_d;
            wdata_q <= wdata_d;
            widx_q  <= widx_d;
            wsel_q  <= wsel_d;
            wrsel_q <= wrsel_d;
            wsize_q <= wsize_d;
`ifdef MPU_LOAD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state and next-data logic. mem_ack is only consulted in REQ, so
    // a stray acknowledge in any other state has no effect.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        dst_d   = dst_q;
        rsel_d  = rsel_q;
        wdata_d = wdata_q;
        widx_d  = widx_q;
        wsel_d  = wsel_q;
        wrsel_d = wrsel_q;
        wsize_d = wsize_q;
`ifdef MPU_LOAD_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    addr_d = ld_addr;
                    size_d = ld_size;
                    dst_d  = ld_dst;
                    rsel_d = ld_r_sel;
`ifdef MPU_LOAD_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                    state_d = misaligned ? ERR : REQ;
                end
            end

            REQ: begin
                // An acknowledge always wins, even in the cycle the wait
                // budget runs out.
                if (mem_ack) begin
                    wdata_d = mem_rdata;
                    widx_d  = dst_q;
                    wsel_d  = addr_q[2:0] >> size_q;
                    wrsel_d = rsel_q;
                    wsize_d = size_q;
                    state_d = WB;
                end
`ifdef MPU_LOAD_TIMEOUT_EN
                // cnt_q counts completed REQ cycles, so TIMEOUT-1 marks the
                // last allowed REQ cycle.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobe outputs decode straight from the state register,
    // so each strobe lasts exactly as long as its one-cycle state.
    assign ld_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign mem_req  = (state_q == REQ);
    assign we       = (state_q == WB);
    assign err      = (state_q == ERR);
    assign mem_addr = {addr_q[ADDR_W-1:3], 3'b000};

    assign w_data   = wdata_q;
    assign w_idx    = widx_q;
    assign w_sel    = wsel_q;
    assign w_r_sel  = wrsel_q;
    assign w_size   = wsize_q;

endmodule

// File: tb/tb_mpu_load_unit.sv
// ----------------------------------------------------------------------------
// tb_mpu_load_unit
// Directed self-checking bench for mpu_load_unit. Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point, so every
// check sees the state produced by the edge just passed.
// ----------------------------------------------------------------------------
module tb_mpu_load_unit;
    import mpu_pkg::*;

    localparam int IDX_W  = 5;
    localparam int ADDR_W = 32;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic [IDX_W-1:0]  ld_dst;
    logic [2:0]        ld_r_sel;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [63:0]       mem_rdata;
    logic [IDX_W-1:0]  w_idx;
    logic [63:0]       w_data;
    logic [2:0]        w_sel;
    logic [2:0]        w_r_sel;
    logic [1:0]        w_size;
    logic              we;
    logic              err;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int weCount;

    mpu_load_unit #(
        .NB_REG (32),
`ifdef MPU_LOAD_TIMEOUT_EN
        .TIMEOUT(4),
`endif
        .ADDR_W (ADDR_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_size  (ld_size),
        .ld_dst   (ld_dst),
        .ld_r_sel (ld_r_sel),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .w_idx    (w_idx),
        .w_data   (w_data),
        .w_sel    (w_sel),
        .w_r_sel  (w_r_sel),
        .w_size   (w_size),
        .we       (we),
        .err      (err),
        .busy     (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size,
                                 input logic [4:0] dst, input logic [2:0] rsel);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_size  = size;
        ld_dst   = dst;
        ld_r_sel = rsel;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_size   = '0;
        ld_dst    = '0;
        ld_r_sel  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        step();
        step();

        // ---------------- reset state ----------------
        checkOutput("rst_ld_ready", 64'(ld_ready), 64'd1);
        checkOutput("rst_mem_req",  64'(mem_req),  64'd0);
        checkOutput("rst_we",       64'(we),       64'd0);
        checkOutput("rst_err",      64'(err),      64'd0);
        checkOutput("rst_busy",     64'(busy),     64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_w_data",   w_data,        64'd0);
        checkOutput("rst_w_idx",    64'(w_idx),    64'd0);
        sys_rst_n = 1'b1;
        step();

        // ---------------- aligned 16-bit load, ack 3 cycles after req ----------------
        applyStimulus(32'h1006, SZ_16, 5'd5, 3'd2);
        step();                                   // cycle 1
        ld_valid = 1'b0;
        checkOutput("al_mem_req_c1",  64'(mem_req),  64'd1);
        checkOutput("al_mem_addr",    64'(mem_addr), 64'h1000);
        checkOutput("al_ld_ready_c1", 64'(ld_ready), 64'd0);
        checkOutput("al_busy_c1",     64'(busy),     64'd1);
        step();                                   // cycle 2
        checkOutput("al_mem_req_c2",  64'(mem_req),  64'd1);
        step();                                   // cycle 3
        step();                                   // cycle 4
        checkOutput("al_mem_req_c4",  64'(mem_req),  64'd1);
        checkOutput("al_mem_addr_c4", 64'(mem_addr), 64'h1000);
        checkOutput("al_we_c4",       64'(we),       64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h1122334455667788;
        step();                                   // cycle 5
        mem_ack   = 1'b0;
        mem_rdata = 64'hDEADBEEFDEADBEEF;
        checkOutput("al_we_c5",    64'(we),      64'd1);
        checkOutput("al_mem_req",  64'(mem_req), 64'd0);
        checkOutput("al_w_idx",    64'(w_idx),   64'd5);
        checkOutput("al_w_sel",    64'(w_sel),   64'd3);
        checkOutput("al_w_r_sel",  64'(w_r_sel), 64'd2);
        checkOutput("al_w_size",   64'(w_size),  64'd1);
        checkOutput("al_w_data",   w_data,       64'h1122334455667788);
        step();                                   // cycle 6
        checkOutput("al_we_c6",       64'(we),       64'd0);
        checkOutput("al_ld_ready_c6", 64'(ld_ready), 64'd1);
        checkOutput("al_w_data_hold", w_data,        64'h1122334455667788);

        // ---------------- misaligned 32-bit load ----------------
        applyStimulus(32'h1003, SZ_32, 5'd6, 3'd1);
        step();
        ld_valid = 1'b0;
        checkOutput("mis_err_c1",     64'(err),      64'd1);
        checkOutput("mis_mem_req_c1", 64'(mem_req),  64'd0);
        checkOutput("mis_we_c1",      64'(we),       64'd0);
        checkOutput("mis_ready_c1",   64'(ld_ready), 64'd0);
        step();
        checkOutput("mis_err_c2",     64'(err),      64'd0);
        checkOutput("mis_mem_req_c2", 64'(mem_req),  64'd0);
        checkOutput("mis_we_c2",      64'(we),       64'd0);
        checkOutput("mis_ready_c2",   64'(ld_ready), 64'd1);
        checkOutput("mis_w_idx_hold", 64'(w_idx),    64'd5);

        // ---------------- back-to-back loads with ack tied high ----------------
        weCount   = 0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hAAAA0000BBBB1111;
        applyStimulus(32'h3000, SZ_32, 5'd7, 3'd1);
        step();                                   // cycle 1: REQ A
        if (we) weCount++;
        checkOutput("b2b_ready_c1", 64'(ld_ready), 64'd0);
        applyStimulus(32'h3004, SZ_32, 5'd9, 3'd4);
        step();                                   // cycle 2: WB A
        if (we) weCount++;
        checkOutput("b2b_ready_c2", 64'(ld_ready), 64'd0);
        checkOutput("b2b_a_w_idx",  64'(w_idx),    64'd7);
        checkOutput("b2b_a_w_sel",  64'(w_sel),    64'd0);
        checkOutput("b2b_a_w_data", w_data,        64'hAAAA0000BBBB1111);
        mem_rdata = 64'hCCCC2222DDDD3333;
        step();                                   // cycle 3: IDLE, B accepted at next edge
        if (we) weCount++;
        checkOutput("b2b_ready_c3", 64'(ld_ready), 64'd1);
        step();                                   // cycle 4: REQ B
        if (we) weCount++;
        ld_valid = 1'b0;
        checkOutput("b2b_ready_c4", 64'(ld_ready), 64'd0);
        checkOutput("b2b_mem_addr", 64'(mem_addr), 64'h3000);
        step();                                   // cycle 5: WB B
        if (we) weCount++;
        checkOutput("b2b_b_we",     64'(we),      64'd1);
        checkOutput("b2b_b_w_idx",  64'(w_idx),   64'd9);
        checkOutput("b2b_b_w_sel",  64'(w_sel),   64'd1);
        checkOutput("b2b_b_w_rsel", 64'(w_r_sel), 64'd4);
        checkOutput("b2b_b_w_data", w_data,       64'hCCCC2222DDDD3333);
        step();                                   // cycle 6: IDLE with stray ack
        if (we) weCount++;
        step();                                   // cycle 7
        if (we) weCount++;
        mem_ack = 1'b0;
        checkOutput("b2b_we_count", 64'(weCount), 64'd2);

        // ---------------- reset during REQ ----------------
        applyStimulus(32'h4008, SZ_8, 5'd3, 3'd0);
        step();                                   // cycle 1: REQ
        ld_valid = 1'b0;
        checkOutput("rreq_mem_req_c1", 64'(mem_req), 64'd1);
        step();                                   // cycle 2: still REQ
        sys_rst_n = 1'b0;
        step();                                   // cycle 3: reset taken
        checkOutput("rreq_mem_req", 64'(mem_req),  64'd0);
        checkOutput("rreq_ready",   64'(ld_ready), 64'd1);
        checkOutput("rreq_w_data",  w_data,        64'd0);
        sys_rst_n = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 64'h0123456789ABCDEF;
        weCount   = 0;
        step();
        if (we) weCount++;
        step();
        if (we) weCount++;
        mem_ack = 1'b0;
        checkOutput("rreq_no_we",   64'(weCount), 64'd0);
        checkOutput("rreq_mem_req_late", 64'(mem_req), 64'd0);

        // ---------------- 64-bit load ----------------
        applyStimulus(32'h2000, SZ_64, 5'd2, 3'd0);
        step();                                   // cycle 1: REQ
        ld_valid  = 1'b0;
        checkOutput("d64_mem_addr", 64'(mem_addr), 64'h2000);
        mem_ack   = 1'b1;
        mem_rdata = 64'hFEDCBA9876543210;
        step();                                   // cycle 2: WB
        mem_ack = 1'b0;
        checkOutput("d64_we",     64'(we),     64'd1);
        checkOutput("d64_w_sel",  64'(w_sel),  64'd0);
        checkOutput("d64_w_size", 64'(w_size), 64'd3);
        checkOutput("d64_w_idx",  64'(w_idx),  64'd2);
        checkOutput("d64_w_data", w_data,      64'hFEDCBA9876543210);
        step();
        checkOutput("d64_we_off", 64'(we), 64'd0);

        // 64-bit field at a non-zero offset can never be aligned.
        applyStimulus(32'h2004, SZ_64, 5'd2, 3'd0);
        step();
        ld_valid = 1'b0;
        checkOutput("d64mis_err",     64'(err),     64'd1);
        checkOutput("d64mis_mem_req", 64'(mem_req), 64'd0);
        step();

`ifdef MPU_LOAD_TIMEOUT_EN
        // ---------------- timeout with no ack ----------------
        applyStimulus(32'h5000, SZ_32, 5'd4, 3'd0);
        step();
        ld_valid = 1'b0;
        weCount  = 0;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("to_mem_req_c%0d", i), 64'(mem_req), 64'd1);
            checkOutput($sformatf("to_err_c%0d", i),     64'(err),     64'd0);
            step();
        end
        checkOutput("to_err",     64'(err),     64'd1);
        checkOutput("to_mem_req", 64'(mem_req), 64'd0);
        checkOutput("to_we",      64'(we),      64'd0);
        step();
        checkOutput("to_ready",   64'(ld_ready), 64'd1);

        // ---------------- ack in the last allowed cycle wins ----------------
        applyStimulus(32'h5008, SZ_32, 5'd4, 3'd0);
        step();                                   // REQ cycle 1
        ld_valid = 1'b0;
        step();                                   // REQ cycle 2
        step();                                   // REQ cycle 3
        step();                                   // REQ cycle 4
        mem_ack   = 1'b1;
        mem_rdata = 64'h5555AAAA5555AAAA;
        step();
        mem_ack = 1'b0;
        checkOutput("tolate_we",     64'(we),  64'd1);
        checkOutput("tolate_err",    64'(err), 64'd0);
        checkOutput("tolate_w_data", w_data,   64'h5555AAAA5555AAAA);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
